// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the data memory arbiter
// Purpose: access-width encoding shared with data_mem, arbiter FSM states.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DB = 2'd0,
    DH = 2'd1,
    DW = 2'd2
  } data_width_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } dmem_arb_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, load extension, misalign detect
// Purpose: combinational lane logic for one access.
// Ports:
//   dw, off, sign   access width, byte offset in word, load sign-extend
//   wdata           LSB-justified store data
//   rdata           raw memory word
//   be, wdata_lane  byte enables and replicated store data
//   rdata_ext       extracted and extended load data
//   misalign        access does not fit its natural alignment
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  data_width_t dw,
  input  logic [1:0]  off,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed byte/half down to bit 0 before extending.
    shifted    = rdata >> {off, 3'b000};
    be         = 4'hF;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misalign   = 1'b0;
    case (dw)
      DB: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign & shifted[7]}}, shifted[7:0]};
      end
      DH: begin
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign & shifted[15]}}, shifted[15:0]};
        misalign   = off[0];
      end
      // DW and the unused encoding behave as a full word.
      default: begin
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter in front of the single-port data memory
// Purpose: grants one requester at a time, issues one memory access, returns
// the extended load data (or a misalign error) to the granted requester.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   req_valid/ready/addr/we/dw/sign/wdata  per-requester request channel
//   rsp_valid/ready, rsp_rdata, rsp_err  response channel (data shared)
//   mem_en/we/be/addr/wdata, mem_rdata   data memory port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*2-1:0]  req_dw,
  input  logic [N_REQ-1:0]    req_sign,
  input  logic [N_REQ*32-1:0] req_wdata,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [AW-1:0]       mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  dmem_arb_state_t state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant;
  logic            found;
  int              idx;

  logic [IW-1:0]   lat_g;
  logic [1:0]      lat_off;
  logic            lat_we;
  data_width_t     lat_dw;
  logic            lat_sign;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   sel_addr;
  logic            sel_we;
  data_width_t     sel_dw;
  logic            sel_sign;
  logic [31:0]     sel_wdata;

  logic [3:0]      be;
  logic [31:0]     wdata_lane;
  logic [31:0]     rdata_ext;
  logic            misalign;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && found) req_ready[grant] = 1'b1;
  end

  assign sel_addr  = req_addr[int'(grant)*AW +: AW];
  assign sel_we    = req_we[grant];
  assign sel_dw    = data_width_t'(req_dw[int'(grant)*2 +: 2]);
  assign sel_sign  = req_sign[grant];
  assign sel_wdata = req_wdata[int'(grant)*32 +: 32];

  // One lane aligner serves both phases: in IDLE it sees the incoming request
  // (store steering, misalign), afterwards the latched request (load extract).
  dmem_lane_align u_align (
    .dw         ((state == IDLE) ? sel_dw : lat_dw),
    .off        ((state == IDLE) ? sel_addr[1:0] : lat_off),
    .sign       ((state == IDLE) ? sel_sign : lat_sign),
    .wdata      (sel_wdata),
    .rdata      (mem_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_g     <= '0;
      lat_off   <= '0;
      lat_we    <= 1'b0;
      lat_dw    <= DB;
      lat_sign  <= 1'b0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            lat_g    <= grant;
            lat_off  <= sel_addr[1:0];
            lat_we   <= sel_we;
            lat_dw   <= sel_dw;
            lat_sign <= sel_sign;
            if (misalign) begin
              rsp_valid[grant] <= 1'b1;
              rsp_err          <= 1'b1;
              rsp_rdata        <= '0;
              state            <= ERR;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_be    <= be;
              mem_addr  <= {sel_addr[AW-1:2], 2'b00};
              mem_wdata <= wdata_lane;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= CW'(MEM_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_rdata        <= lat_we ? 32'h0 : rdata_ext;
            rsp_err          <= 1'b0;
            rsp_valid[lat_g] <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP, ERR: begin
          if (rsp_ready[lat_g]) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= (lat_g == IW'(N_REQ - 1)) ? '0 : lat_g + IW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_we;
  logic [N*2-1:0]  req_dw;
  logic [N-1:0]    req_sign;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            mem_en;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic [31:0]     mem_word;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem_word;

  dmem_arbiter #(.N_REQ(N), .MEM_LAT(1), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_dw(req_dw), .req_sign(req_sign), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] addr, input logic we,
                         input logic [1:0] dw, input logic sign, input logic [31:0] wdata);
    req_valid[r]           = v;
    req_addr[r*AW +: AW]   = addr;
    req_we[r]              = we;
    req_dw[r*2 +: 2]       = dw;
    req_sign[r]            = sign;
    req_wdata[r*32 +: 32]  = wdata;
  endtask

  // One uncontended access; all expectations are supplied by the caller.
  task automatic access(input string tag, input int r, input logic [31:0] addr, input logic we,
                        input logic [1:0] dw, input logic sign, input logic [31:0] wdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    set_req(r, 1'b1, addr, we, dw, sign, wdata);
    #1;
    check_vec({tag, ".ready"}, 32'(req_ready), 32'(1 << r));
    step();
    req_valid[r] = 1'b0;
    if (exp_err) begin
      check_vec({tag, ".no_mem_en"}, 32'(mem_en), 32'd0);
      check_vec({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
      check_vec({tag, ".err"}, 32'(rsp_err), 32'd1);
      check_vec({tag, ".rdata"}, rsp_rdata, 32'h0);
    end else begin
      check_vec({tag, ".mem_en"}, 32'(mem_en), 32'd1);
      check_vec({tag, ".mem_we"}, 32'(mem_we), 32'(we));
      check_vec({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
      check_vec({tag, ".mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
      if (we) check_vec({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
      step();
      check_vec({tag, ".wait_no_rsp"}, 32'(rsp_valid), 32'd0);
      check_vec({tag, ".strobe_once"}, 32'(mem_en), 32'd0);
      step();
      check_vec({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
      check_vec({tag, ".err"}, 32'(rsp_err), 32'd0);
      check_vec({tag, ".rdata"}, rsp_rdata, exp_rdata);
    end
    rsp_ready[r] = 1'b1;
    step();
    rsp_ready[r] = 1'b0;
    check_vec({tag, ".consumed"}, 32'(rsp_valid), 32'd0);
    check_vec({tag, ".err_mem_en"}, 32'(mem_en), 32'd0);
  endtask

  int n_grant;
  int viol;
  int gseq[4];
  int seen;
  int rdy_seen;
  int post;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_we    = '0;
    req_dw    = '0;
    req_sign  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    mem_word  = 32'h0;

    // Reset: ready held low even with a request pending.
    req_valid = 2'b01;
    step();
    step();
    check_vec("rst.req_ready", 32'(req_ready), 32'd0);
    check_vec("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_vec("rst.mem_en", 32'(mem_en), 32'd0);
    check_vec("rst.mem_be", 32'(mem_be), 32'd0);
    check_vec("rst.mem_addr", mem_addr, 32'd0);
    check_vec("rst.rsp_rdata", rsp_rdata, 32'd0);
    req_valid = '0;
    rst = 1'b0;
    step();

    mem_word = 32'hDEADBEEF;
    access("dw_load", 0, 32'h10, 1'b0, DW, 1'b0, 32'h0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    access("db_store", 0, 32'h3, 1'b1, DB, 1'b0, 32'h000000F4, 4'b1000, 32'hF4F4F4F4, 32'h0, 1'b0);
    mem_word = 32'hF4000000;
    access("db_sload", 0, 32'h3, 1'b0, DB, 1'b1, 32'h0, 4'b1000, 32'h0, 32'hFFFFFFF4, 1'b0);
    access("db_uload", 0, 32'h3, 1'b0, DB, 1'b0, 32'h0, 4'b1000, 32'h0, 32'h000000F4, 1'b0);
    mem_word = 32'hF3F40102;
    access("dh_sload", 0, 32'h2, 1'b0, DH, 1'b1, 32'h0, 4'b1100, 32'h0, 32'hFFFFF3F4, 1'b0);
    access("dh_uload1", 1, 32'h2, 1'b0, DH, 1'b0, 32'h0, 4'b1100, 32'h0, 32'h0000F3F4, 1'b0);
    access("db_sload0", 1, 32'h1, 1'b0, DB, 1'b1, 32'h0, 4'b0010, 32'h0, 32'h00000001, 1'b0);
    access("dh_store1", 1, 32'h22, 1'b1, DH, 1'b0, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    access("mis_dw", 0, 32'h6, 1'b0, DW, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
    access("mis_dh", 1, 32'h5, 1'b1, DH, 1'b0, 32'h55, 4'h0, 32'h0, 32'h0, 1'b1);

    // Contention: last served was requester 1, so the order starts at 0.
    mem_word = 32'h01020304;
    set_req(0, 1'b1, 32'h10, 1'b0, DW, 1'b0, 32'h0);
    set_req(1, 1'b1, 32'h20, 1'b0, DW, 1'b0, 32'h0);
    rsp_ready = 2'b11;
    #1;
    n_grant = 0;
    viol = 0;
    for (int c = 0; c < 60 && n_grant < 4; c++) begin
      if ($countones(rsp_valid) > 1) viol++;
      if ((req_valid & req_ready) != 0) begin
        gseq[n_grant] = req_ready[1] ? 1 : 0;
        n_grant++;
      end
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      if ($countones(rsp_valid) > 1) viol++;
      step();
    end
    rsp_ready = '0;
    check_vec("cont.grants", 32'(n_grant), 32'd4);
    for (int k = 0; k < 4; k++) check_vec($sformatf("cont.grant%0d", k), 32'(gseq[k]), 32'(k % 2));
    check_vec("cont.onehot_rsp", 32'(viol), 32'd0);

    // Stall: requester 1 withholds rsp_ready; requester 0 must not be granted.
    set_req(1, 1'b1, 32'h8, 1'b0, DW, 1'b0, 32'h0);
    #1;
    step();
    req_valid[1] = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (rsp_valid[1]) seen = 1;
      else step();
    end
    check_vec("stall.rsp_seen", 32'(seen), 32'd1);
    set_req(0, 1'b1, 32'h14, 1'b0, DW, 1'b0, 32'h0);
    #1;
    rdy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready != 0) rdy_seen++;
      step();
    end
    check_vec("stall.no_ready", 32'(rdy_seen), 32'd0);
    check_vec("stall.rsp_held", 32'(rsp_valid), 32'b10);
    req_valid[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    step();
    rsp_ready[1] = 1'b0;
    check_vec("stall.released", 32'(rsp_valid), 32'd0);

    // Reset while the next access sits in WAIT.
    set_req(0, 1'b1, 32'h14, 1'b0, DW, 1'b0, 32'h0);
    #1;
    step();
    req_valid[0] = 1'b0;
    check_vec("midrst.issue", 32'(mem_en), 32'd1);
    step();
    rst = 1'b1;
    step();
    check_vec("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_vec("midrst.mem_en", 32'(mem_en), 32'd0);
    check_vec("midrst.mem_be", 32'(mem_be), 32'd0);
    check_vec("midrst.mem_addr", mem_addr, 32'd0);
    check_vec("midrst.mem_wdata", mem_wdata, 32'd0);
    check_vec("midrst.mem_we", 32'(mem_we), 32'd0);
    check_vec("midrst.rsp_rdata", rsp_rdata, 32'd0);
    check_vec("midrst.rsp_err", 32'(rsp_err), 32'd0);
    check_vec("midrst.req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    rsp_ready = 2'b11;
    post = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid != 0 || mem_en) post++;
      step();
    end
    rsp_ready = '0;
    check_vec("midrst.no_rsp_after", 32'(post), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
